sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO with the same push/pop interface as the team's dual-clock FIFO. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. It is used wherever producer and consumer share one clock and a CDC FIFO would cost needless area and latency.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_flags.sv | 120 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and width helper for the FIFO family
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_DEPTH  = 16;

    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    // Ceiling log2; clog2(1) = 0, clog2(16) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - dual-port storage, synchronous write, asynchronous read
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with thresholds, count, sticky errors, optional FWFT
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = MODE_REG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    re,
    input  logic [DATA_W-1:0]       din,
    input  logic                    clr_err,
    output logic [DATA_W-1:0]       dout,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_data;

    // Status comes from the registered count only, so no we/re path reaches it.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_acc      = we & ~full;
        rd_acc      = re & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A new error event in the clearing cycle must not be lost.
        overflow_d  = (overflow_q  & ~clr_err) | (we & full);
        underflow_d = (underflow_q & ~clr_err) | (re & empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign dout = empty ? '0 : rd_data;
    end else begin : g_reg
        logic [DATA_W-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) begin
                dout_d = rd_data;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed scoreboard bench for sync_fifo_flags in both read modes
module tb_sync_fifo_flags;

    logic        clk;
    logic        rst;
    logic        we, re, clr_err;
    logic [15:0] din;
    logic [15:0] dout;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  count;

    logic        f_we, f_re;
    logic [15:0] f_din;
    logic [15:0] f_dout;
    logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [4:0]  f_count;

    int checks;
    int failures;

    logic [15:0] sb[$];
    int          m_cnt;
    logic        m_ovf, m_unf;
    logic [15:0] m_dout;

    sync_fifo_flags #(.DATA_W(16), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din), .clr_err(clr_err),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flags #(.DATA_W(16), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .we(f_we), .re(f_re), .din(f_din), .clr_err(1'b0),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_afull),
        .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt == 16));
        chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(m_cnt >= 14));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_cnt <= 2));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 16'h0;
    endtask

    // One clock of the registered-read instance; inputs driven #1 after the edge.
    task automatic cyc(input string tag, input logic w, input logic r,
                       input logic [15:0] d, input logic c);
        logic wa, ra;
        we = w; re = r; din = d; clr_err = c;
        wa = w && (m_cnt != 16);
        ra = r && (m_cnt != 0);
        m_ovf = (m_ovf & ~c) | (w && m_cnt == 16);
        m_unf = (m_unf & ~c) | (r && m_cnt == 0);
        @(posedge clk);
        if (ra) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                m_dout = sb.pop_front();
            end
        end
        if (wa) sb.push_back(d);
        m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        #1;
        we = 1'b0; re = 1'b0; clr_err = 1'b0;
        chk_state(tag);
    endtask

    task automatic fcyc(input logic w, input logic r, input logic [15:0] d);
        f_we = w; f_re = r; f_din = d;
        @(posedge clk);
        #1;
        f_we = 1'b0; f_re = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        we = 0; re = 0; din = 0; clr_err = 0;
        f_we = 0; f_re = 0; f_din = 0;
        model_reset();

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_state("reset");
        chk("reset.f_dout", 32'(f_dout), 32'h0);
        chk("reset.f_empty", 32'(f_empty), 32'd1);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 1'b0, 16'(i), 1'b0);
        cyc("ovf", 1'b1, 1'b0, 16'hDEAD, 1'b0);
        cyc("ovf_clr_set", 1'b1, 1'b0, 16'hBEEF, 1'b1);
        cyc("ovf_clr", 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 1'b1, 16'h0, 1'b0);
        cyc("unf", 1'b0, 1'b1, 16'h0, 1'b0);
        cyc("unf_hold", 1'b0, 1'b0, 16'h0, 1'b0);
        cyc("unf_clr", 1'b0, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 8; i++) cyc("pre8", 1'b1, 1'b0, 16'h200 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) cyc("rw", 1'b1, 1'b1, 16'h100 + 16'(i), 1'b0);
        for (int i = 0; i < 8; i++) cyc("post_rw", 1'b0, 1'b1, 16'h0, 1'b0);

        fcyc(1'b1, 1'b0, 16'hABCD);
        chk("fwft.dout_first", 32'(f_dout), 32'hABCD);
        chk("fwft.empty_drop", 32'(f_empty), 32'd0);
        fcyc(1'b0, 1'b1, 16'h0);
        chk("fwft.dout_after_pop", 32'(f_dout), 32'h0);
        chk("fwft.empty_after_pop", 32'(f_empty), 32'd1);
        fcyc(1'b1, 1'b0, 16'h1111);
        fcyc(1'b1, 1'b0, 16'h2222);
        chk("fwft.head", 32'(f_dout), 32'h1111);
        fcyc(1'b0, 1'b1, 16'h0);
        chk("fwft.advance", 32'(f_dout), 32'h2222);
        fcyc(1'b0, 1'b1, 16'h0);
        chk("fwft.drained", 32'(f_dout), 32'h0);
        chk("fwft.unf", 32'(f_unf), 32'd0);

        for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, 1'b0, 16'h300 + 16'(i), 1'b0);
        cyc("pre_rst_rd", 1'b0, 1'b1, 16'h0, 1'b0);
        cyc("pre_rst_wr", 1'b1, 1'b0, 16'h305, 1'b0);
        fcyc(1'b1, 1'b0, 16'h7777);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_state("async_rst");
        chk("async_rst.f_dout", 32'(f_dout), 32'h0);
        chk("async_rst.f_count", 32'(f_count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("post_rst_wr", 1'b1, 1'b0, 16'h5A5A, 1'b0);
        cyc("post_rst_rd", 1'b0, 1'b1, 16'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
